// File: rtl/outerprodrc_pkg.sv
// Shared types and helpers for the rate-coded outer-product accumulator.
// State enum, width derivation, bit reversal and saturation.
package outerprodrc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Reverse the low m bits of v.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int m
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r >> (32 - m);
  endfunction

  function automatic int accw(input int bw, input int hidden);
    return (bw - 1) + clog2(hidden) + 2;
  endfunction

  function automatic logic signed [31:0] saturate(
    input logic signed [31:0] v,
    input int w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/outerprodrc_acc_pe.sv
// One output cell: signed popcount of HIDDEN product bits,
// wide accumulator and saturated view of the running sum.
module outerprodrc_acc_pe
  import outerprodrc_pkg::*;
#(
  parameter int HIDDEN      = 4,
  parameter int ACCW        = 8,
  parameter int OUTBITWIDTH = 12
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic [HIDDEN-1:0]      hit,
  input  logic [HIDDEN-1:0]      neg,
  output logic [OUTBITWIDTH-1:0] q
);

  localparam int DW = clog2(HIDDEN) + 2;
  localparam logic signed [DW-1:0] ONE = DW'(1);

  logic signed [DW-1:0]   delta;
  logic signed [ACCW-1:0] acc;

  always_comb begin
    delta = '0;
    for (int k = 0; k < HIDDEN; k++)
      if (hit[k]) delta = neg[k] ? delta - ONE : delta + ONE;
  end

  always_ff @(posedge clk) begin
    if (clr) acc <= '0;
    else if (en) acc <= acc + ACCW'(delta);
  end

  assign q = OUTBITWIDTH'(saturate(32'(acc), OUTBITWIDTH));

endmodule

// File: rtl/outerprodrc_acc.sv
// Rate-coded signed outer-product tile: FSM, stream counter,
// operand registers, comparators and result register.
module outerprodrc_acc
  import outerprodrc_pkg::*;
#(
  parameter int ROWNUM      = 4,
  parameter int COLNUM      = 4,
  parameter int HIDDEN      = 4,
  parameter int BITWIDTH    = 8,
  parameter int OUTBITWIDTH = 12
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iEn,
  input  logic                                iClr,
  input  logic                                iValid,
  output logic                                oReady,
  input  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]   iData0,
  input  logic [HIDDEN*COLNUM*BITWIDTH-1:0]   iData1,
  output logic                                oValid,
  input  logic                                iReady,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData
);

  localparam int M    = BITWIDTH - 1;
  localparam int ACCW = accw(BITWIDTH, HIDDEN);
  localparam logic [M-1:0] TLAST = '1;

  state_t state, nstate;
  logic [M-1:0] t, trev;
  logic [HIDDEN*ROWNUM*BITWIDTH-1:0] d0;
  logic [HIDDEN*COLNUM*BITWIDTH-1:0] d1;
  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] res;
  logic accept, step, last, ack, cap;
  logic pe_clr;

  always_comb begin
    nstate = state;
    accept = 1'b0;
    step   = 1'b0;
    last   = 1'b0;
    ack    = 1'b0;
    unique case (state)
      IDLE: if (iValid) begin
        accept = 1'b1;
        nstate = RUN;
      end
      RUN: if (iEn) begin
        step = 1'b1;
        if (t == TLAST) begin
          last   = 1'b1;
          nstate = DONE;
        end
      end
      DONE: if (oValid && iReady) begin
        ack    = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
    if (iClr) begin
      nstate = IDLE;
      accept = 1'b0;
      step   = 1'b0;
      last   = 1'b0;
      ack    = 1'b0;
    end
  end

  // The final step lands in the PEs on the same edge as the move to
  // DONE, so the result is captured one cycle later via cap.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= IDLE;
      t      <= '0;
      d0     <= '0;
      d1     <= '0;
      cap    <= 1'b0;
      oValid <= 1'b0;
      oData  <= '0;
    end else begin
      state <= nstate;
      if (iClr) begin
        t      <= '0;
        cap    <= 1'b0;
        oValid <= 1'b0;
      end else begin
        cap <= last;
        if (accept) begin
          d0 <= iData0;
          d1 <= iData1;
          t  <= '0;
        end else if (step) begin
          t <= t + 1'b1;
        end
        if (cap) begin
          oData  <= res;
          oValid <= 1'b1;
        end else if (ack) begin
          oValid <= 1'b0;
        end
      end
    end
  end

  assign oReady = (state == IDLE);
  assign trev   = M'(bitrev(32'(t), M));
  assign pe_clr = iRst | iClr | accept;

  logic [HIDDEN-1:0] rb [ROWNUM];
  logic [HIDDEN-1:0] rs [ROWNUM];
  logic [HIDDEN-1:0] cb [COLNUM];
  logic [HIDDEN-1:0] cs [COLNUM];

  for (genvar k = 0; k < HIDDEN; k++) begin : g_k
    for (genvar i = 0; i < ROWNUM; i++) begin : g_r
      localparam int B = (k * ROWNUM + i) * BITWIDTH;
      assign rb[i][k] = d0[B +: M] > t;
      assign rs[i][k] = d0[B + M];
    end
    for (genvar j = 0; j < COLNUM; j++) begin : g_c
      localparam int B = (k * COLNUM + j) * BITWIDTH;
      assign cb[j][k] = d1[B +: M] > trev;
      assign cs[j][k] = d1[B + M];
    end
  end

  for (genvar i = 0; i < ROWNUM; i++) begin : g_i
    for (genvar j = 0; j < COLNUM; j++) begin : g_j
      outerprodrc_acc_pe #(
        .HIDDEN     (HIDDEN),
        .ACCW       (ACCW),
        .OUTBITWIDTH(OUTBITWIDTH)
      ) u_pe (
        .clk(iClk),
        .clr(pe_clr),
        .en (step),
        .hit(rb[i] & cb[j]),
        .neg(rs[i] ^ cs[j]),
        .q  (res[(i*COLNUM+j)*OUTBITWIDTH +: OUTBITWIDTH])
      );
    end
  end

endmodule

// File: tb/tb_outerprodrc_acc.sv
// Directed bench for outerprodrc_acc: two instances (12- and 4-bit
// results) share stimulus; a scoreboard queue holds expected tiles.
module tb_outerprodrc_acc;

  localparam int R   = 2;
  localparam int C   = 2;
  localparam int H   = 4;
  localparam int BW  = 4;
  localparam int OWA = 12;
  localparam int OWB = 4;
  localparam int L   = 8;

  logic iClk = 1'b0;
  logic iRst, iEn, iClr, iValid, iReady;
  logic [H*R*BW-1:0] iData0;
  logic [H*C*BW-1:0] iData1;
  logic oReadyA, oValidA, oReadyB, oValidB;
  logic [R*C*OWA-1:0] oDataA;
  logic [R*C*OWB-1:0] oDataB;

  int n_chk  = 0;
  int n_fail = 0;
  logic [R*C*OWA-1:0] qa[$];
  logic [R*C*OWB-1:0] qb[$];
  logic [R*C*OWA-1:0] lastA;
  logic [R*C*OWB-1:0] lastB;

  always #5 iClk = ~iClk;

  outerprodrc_acc #(
    .ROWNUM(R), .COLNUM(C), .HIDDEN(H), .BITWIDTH(BW), .OUTBITWIDTH(OWA)
  ) dutA (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
    .iValid(iValid), .oReady(oReadyA), .iData0(iData0), .iData1(iData1),
    .oValid(oValidA), .iReady(iReady), .oData(oDataA)
  );

  outerprodrc_acc #(
    .ROWNUM(R), .COLNUM(C), .HIDDEN(H), .BITWIDTH(BW), .OUTBITWIDTH(OWB)
  ) dutB (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
    .iValid(iValid), .oReady(oReadyB), .iData0(iData0), .iData1(iData1),
    .oValid(oValidB), .iReady(iReady), .oData(oDataB)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Reference: walk all L steps explicitly per cell, then clamp.
  function automatic logic [R*C*OWA-1:0] model(
    input logic [H*R*BW-1:0] a, input logic [H*C*BW-1:0] b, input int ow
  );
    logic [R*C*OWA-1:0] res;
    int acc, hi, lo;
    logic [2:0] tt, tr, ma, mb;
    logic sa, sb;
    res = '0;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        acc = 0;
        for (int t = 0; t < L; t++) begin
          tt = 3'(t);
          tr = {tt[0], tt[1], tt[2]};
          for (int k = 0; k < H; k++) begin
            ma = a[(k*R+i)*BW +: 3];
            sa = a[(k*R+i)*BW + 3];
            mb = b[(k*C+j)*BW +: 3];
            sb = b[(k*C+j)*BW + 3];
            if (ma > tt && mb > tr) acc += (sa ^ sb) ? -1 : 1;
          end
        end
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
        for (int x = 0; x < ow; x++) res[(i*C+j)*ow + x] = acc[x];
      end
    return res;
  endfunction

  task automatic fill(input logic [2:0] rm, input logic rn,
                      input logic [2:0] cm, input logic cn);
    for (int k = 0; k < H; k++) begin
      for (int i = 0; i < R; i++) iData0[(k*R+i)*BW +: BW] = {rn, rm};
      for (int j = 0; j < C; j++) iData1[(k*C+j)*BW +: BW] = {cn, cm};
    end
  endtask

  task automatic send(input bit push);
    logic [R*C*OWA-1:0] eb;
    int n;
    n = 0;
    while (!oReadyA && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(oReadyA), 64'd1);
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    if (push) begin
      qa.push_back(model(iData0, iData1, OWA));
      eb = model(iData0, iData1, OWB);
      qb.push_back(eb[R*C*OWB-1:0]);
    end
  endtask

  // mode 0: iEn held high; mode 1: iEn low on odd cycles first.
  task automatic get_result(input string tag, input int mode,
                            input int explat, input int hold);
    logic [R*C*OWA-1:0] ea;
    logic [R*C*OWB-1:0] eb;
    int n;
    n = 0;
    while (n < 100) begin
      n++;
      iEn = (mode == 0) ? 1'b1 : ((n % 2) == 0);
      tick();
      if (oValidA) break;
    end
    iEn = 1'b1;
    chk({tag, "_valid"}, 64'(oValidA), 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'(explat));
    chk({tag, "_sb"}, 64'(qa.size() != 0), 64'd1);
    if (qa.size() == 0) return;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk({tag, "_A"}, 64'(oDataA), 64'(ea));
    chk({tag, "_B"}, 64'(oDataB), 64'(eb));
    for (int h = 0; h < hold; h++) begin
      iValid = (h == 2);
      if (h == 2) fill(3'd1, 1'b0, 3'd1, 1'b0);
      tick();
      chk({tag, "_holdv"}, 64'(oValidA), 64'd1);
      chk({tag, "_holdA"}, 64'(oDataA), 64'(ea));
      chk({tag, "_holdr"}, 64'(oReadyA), 64'd0);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    chk({tag, "_ackv"}, 64'(oValidA), 64'd0);
    chk({tag, "_ackr"}, 64'(oReadyA), 64'd1);
    lastA = ea;
    lastB = eb;
  endtask

  initial begin
    iRst = 1'b1; iEn = 1'b1; iClr = 1'b0;
    iValid = 1'b0; iReady = 1'b0;
    iData0 = '0; iData1 = '0;
    tick();
    tick();
    iRst = 1'b0;
    chk("rst_valid", 64'(oValidA), 64'd0);
    chk("rst_ready", 64'(oReadyA), 64'd1);
    chk("rst_dataA", 64'(oDataA), 64'd0);
    chk("rst_dataB", 64'(oDataB), 64'd0);

    fill(3'd7, 1'b0, 3'd7, 1'b0);
    chk("model_pos7", 64'(model(iData0, iData1, OWA)), 64'h01c01c01c01c);
    send(1'b1);
    get_result("pos7", 0, L + 1, 0);

    fill(3'd4, 1'b1, 3'd4, 1'b0);
    send(1'b1);
    get_result("neg4", 0, L + 1, 0);

    fill(3'd7, 1'b1, 3'd7, 1'b0);
    chk("model_sat", 64'(model(iData0, iData1, OWB)), 64'h8888);
    send(1'b1);
    get_result("neg7", 0, L + 1, 0);

    fill(3'd0, 1'b1, 3'd7, 1'b0);
    send(1'b1);
    get_result("negzero", 0, L + 1, 0);

    fill(3'd7, 1'b0, 3'd7, 1'b0);
    send(1'b1);
    get_result("toggle", 1, 2 * L + 1, 0);

    iData0 = 32'h9a3c_5e71;
    iData1 = 32'hc4b2_7f08;
    send(1'b1);
    get_result("hold", 0, L + 1, 5);

    fill(3'd5, 1'b0, 3'd6, 1'b1);
    send(1'b0);
    tick();
    tick();
    tick();
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    chk("clr_ready", 64'(oReadyA), 64'd1);
    chk("clr_valid", 64'(oValidA), 64'd0);
    chk("clr_dataA", 64'(oDataA), 64'(lastA));
    chk("clr_dataB", 64'(oDataB), 64'(lastB));
    for (int c = 0; c < 12; c++) tick();
    chk("clr_quiet", 64'(oValidA), 64'd0);

    send(1'b0);
    tick();
    tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("mrst_ready", 64'(oReadyA), 64'd1);
    chk("mrst_valid", 64'(oValidA), 64'd0);
    chk("mrst_dataA", 64'(oDataA), 64'd0);

    iData0 = $urandom;
    iData1 = $urandom;
    send(1'b1);
    get_result("rand", 0, L + 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/outerprodrc_acc.md
Name: outerprodrc_acc

Overview:
- Parametrised, handshaked successor to the unary outer-product GEMM tile.
- Accepts one signed (sign-magnitude) operand set: HIDDEN row vectors and HIDDEN column vectors. Generates rate-coded bitstreams internally over L = 2^(BITWIDTH-1) cycles.
- Accumulates signed outer products of all HIDDEN slices into per-cell saturating two's-complement counters, then presents an ROWNUM x COLNUM binary result under valid/ready.
- Sits between the operand buffers and the output writeback of the unary GEMM array.

Parameters:
- ROWNUM, 4, rows of the output tile.
- COLNUM, 4, columns of the output tile.
- HIDDEN, 4, reduction depth (vector slices summed per cell).
- BITWIDTH, 8, operand width: MSB is sign, low BITWIDTH-1 bits are magnitude; must be >= 2.
- OUTBITWIDTH, 12, result width per cell in two's complement; results saturate to this width.

Ports:
- iClk, in, 1, clock; all logic on the rising edge.
- iRst, in, 1, reset, synchronous, active-high.
- iEn, in, 1, RUN-phase advance enable; when low, the stream counter and accumulators hold.
- iClr, in, 1, synchronous abort: return to IDLE, zero the accumulators, drop oValid.
- iValid, in, 1, operand set valid.
- oReady, out, 1, high in IDLE only.
- iData0, in, HIDDEN*ROWNUM*BITWIDTH, row operands; element (k,i) at [(k*ROWNUM+i)*BITWIDTH +: BITWIDTH].
- iData1, in, HIDDEN*COLNUM*BITWIDTH, column operands; element (k,j) at [(k*COLNUM+j)*BITWIDTH +: BITWIDTH].
- oValid, out, 1, result valid.
- iReady, in, 1, downstream accepts result.
- oData, out, ROWNUM*COLNUM*OUTBITWIDTH, cell (i,j) at [(i*COLNUM+j)*OUTBITWIDTH +: OUTBITWIDTH].

Behaviour:
- Reset (iRst=1): state IDLE, oValid=0, oReady=1, oData=0, counter t=0, accumulators 0.
- Priority: iRst > iClr > handshake/RUN logic.
- FSM states and transitions:
  - IDLE: oReady=1. When iValid=1, latch iData0/iData1, clear the accumulators, set t=0, go to RUN.
  - RUN: oReady=0. When iEn=1, perform one accumulate step and increment t. On the step where t=L-1, register the accumulators into oData and go to DONE. When iEn=0, hold everything.
  - DONE: oValid=1, oData stable. When iReady=1, clear oValid and go to IDLE. The next operand set can be accepted no earlier than the following cycle.
- Latency with iEn held high: operands accepted at edge 0; oValid rises after edge L+1. Each stalled iEn cycle adds one cycle.
- Stream generation, per step at count t (M = BITWIDTH-1 bits):
  - Row bit for magnitude a: r = (a > t).
  - Column bit for magnitude b: c = (b > bitrev_M(t)).
  - The bit-reversed comparison decorrelates the two streams.
- Per cell (i,j), per step:
  - For each k: p_k = r(k,i) & c(k,j), sign s_k = sign(k,i) XOR sign(k,j).
  - Step delta = sum over k of (s_k ? -p_k : +p_k), range [-HIDDEN, HIDDEN].
  - The step delta is computed combinationally, with no chained-carry reuse across cells.
- Accumulator width:
  - Internal width ACCW = (BITWIDTH-1) + clog2(HIDDEN) + 2; it never overflows.
  - When the value is registered into oData, saturate to [-2^(OUTBITWIDTH-1), 2^(OUTBITWIDTH-1)-1].
- Zero magnitude: a magnitude of 0 with the sign bit set (negative zero) contributes nothing.
- Events:
  - iValid in RUN or DONE is ignored; oReady=0, so no operand is lost by protocol.
  - iClr in any state: next cycle IDLE, accumulators 0, oValid=0. oData keeps its last value.
  - iRst mid-RUN: same as iClr, plus oData=0.

Decomposition:
- Shared package outerprodrc_pkg holds:
  - the state enumeration (IDLE/RUN/DONE);
  - the functions clog2 and bitrev;
  - the ACCW derivation and the saturate function.
- One natural sub-module, outerprodrc_acc_pe: a single cell with HIDDEN-input signed popcount, accumulator and saturation.
  - The top module holds the FSM, t counter, operand registers, comparators and output registers.
  - The top module instantiates ROWNUM*COLNUM PEs.

Test Plan:
All cases use BITWIDTH=4 (L=8), HIDDEN=4, ROWNUM=COLNUM=2 unless noted.
- All magnitudes 7, all positive, iEn=1 → every cell 28; oValid first high after edge 9.
- All magnitudes 4, row signs negative, column signs positive → every cell -8 (2 hits per k × 4).
- All magnitudes 7, same operands with OUTBITWIDTH=4 → every cell saturates to 7; with row signs negative, every cell saturates to -8.
- Row magnitude 0 with sign=1 (negative zero), columns 7 → every cell 0.
- iEn toggled 1/0 every cycle during RUN → same result as the iEn=1 case; latency 2L+1 cycles.
- Result presented with iReady=0 for 5 cycles → oData and oValid held; iValid pulsed meanwhile is ignored. Then iClr mid-RUN on the next set → oValid stays 0 and the FSM returns to IDLE (oReady=1) next cycle.
